vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Frame-buffer access controller between the VGA timing generator and game/drawing logic.
- Owns the single-port pixel RAM, a 160x120 frame buffer with each pixel scaled 4x to 640x480.
- Schedules one scan-out read per 4-pixel group. That read always has priority. Writer requests are granted in every remaining clock cycle.
- Registers fetched colours so the colour is valid on the pixel where posx/posy are presented.

Parameters:
- FB_W, 160, frame-buffer width in pixels.
- FB_H, 120, frame-buffer height in pixels.
- SCALE_LOG2, 2, log2 of the screen-to-frame-buffer scale factor.
- COLOR_W, 8, colour word width.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- H_VIS, 640, visible pixels per line.
- H_TOTAL, 800, pixels per line including blanking.
- V_VIS, 480, visible lines.
- V_TOTAL, 525, lines per frame.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  one-clk pulse per pixel (every 2nd clk); posx/posy advance on the clk after it.
- posx  in  10  current pixel column, 0..H_TOTAL-1.
- posy  in  10  current line, 0..V_TOTAL-1.
- blank_n  in  1  high in the visible region.
- wr_req  in  1  writer request; level, held until wr_ack.
- wr_addr  in  ADDR_W  frame-buffer address, y*FB_W+x; stable while wr_req is high.
- wr_data  in  COLOR_W  write colour; stable while wr_req is high.
- wr_ack  out  1  one-clk pulse; the request is consumed in this cycle.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  COLOR_W  RAM write data, registered.
- mem_rdata  in  COLOR_W  RAM read data, valid 1 clk after the read address is presented.
- pix_color  out  COLOR_W  colour for the current pixel; 0 when blank_n=0.

Behaviour:
- Reset (async, rst_n=0) clears: mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, prefetch register=0, display register=0, rd_pending=0, FSM state=IDLE. Reset mid-transaction drops any pending write without an ack; the writer re-requests.
- Group index: g = posx>>SCALE_LOG2; row r = posy>>SCALE_LOG2.
- Fetch trigger: on a pix_en clk with posx[1:0]==0, rd_pending is set and the target address is latched.
  - If posx < H_VIS-4, target = r*FB_W + g+1 (next group on this line).
  - If posx == H_TOTAL-4, target = r'*FB_W + 0, where y' = (posy==V_TOTAL-1) ? 0 : posy+1 and r' = y'>>SCALE_LOG2. This is only done when y' < V_VIS.
  - Otherwise there is no fetch.
- Group 0 of visible line 0 is prefetched from the end of line V_TOTAL-1.
- FSM states: IDLE, RD, CAP.
  - IDLE: if rd_pending, go to RD; else if wr_req and no ack this cycle, issue a write and stay in IDLE.
  - RD: mem_addr=target, mem_we=0; clear rd_pending; go to CAP.
  - CAP: prefetch register <= mem_rdata. A write may be issued in the same cycle. Go to IDLE.
- Worst-case read completion is 3 clks after the trigger. This is always before the next group boundary, which is 8 clks later.
- Display register <= prefetch register on a pix_en clk with posx[1:0]==3, so the new group appears at posx[1:0]==0.
- pix_color = blank_n ? display register : 0. This mask is combinational.
- Write issue: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data, wr_ack=1 for exactly that cycle. mem_we deasserts the next cycle unless another write is issued.
  - After an ack, the same request is not re-issued in the following cycle. The writer must drop wr_req or present a new transaction, and at least 1 idle clk separates back-to-back acks.
- Out-of-range write (wr_addr >= FB_W*FB_H): wr_ack is pulsed, mem_we stays 0, and the RAM is unchanged.
- Simultaneous read trigger and wr_req: the read wins and wr_ack is delayed. Write starvation is bounded at 2 clks per 8-clk group.
- Blanking region: no reads except the end-of-line prefetch, so all other slots are free for writes.

Test Plan:
- Reset, preload RAM addr 0 = 0x11, addr 1 = 0x22, run from posx=796, posy=524 -> pix_color=0x11 at posx 0..3 and 0x22 at posx 4..7 on line 0.
- Hold wr_req with addr 5, data 0xA5 through a fetch trigger -> RD then CAP occur first; wr_ack is delayed until the read has been issued; RAM[5]=0xA5; exactly one mem_we pulse.
- Continuous wr_req (new addr/data after each ack) over one visible line -> every scan-out read is served within 3 clks; pix_color matches the golden model for all 640 pixels.
- Write to addr 19200 -> wr_ack pulses, mem_we=0, RAM unchanged.
- Write addr 160 (row 1, col 0) = 0x7E before line 4 -> posy=4, posx 0..3 shows 0x7E; posy=3 is unaffected.
- Assert rst_n=0 while mem_we=1 -> mem_we, wr_ack and pix_color are 0 immediately; after release, the FSM is in IDLE and the next frame displays correctly.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - writer request/acknowledge handshake into the frame-buffer arbiter
interface vga_fb_arbiter_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 8
);
    logic               wr_req;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
    modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port frame-buffer arbiter: scan-out prefetch with priority, writes in free slots
module vga_fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int COLOR_W    = 8,
    parameter int ADDR_W     = 15,
    parameter int H_VIS      = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_VIS      = 480,
    parameter int V_TOTAL    = 525
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic [9:0]         posx,
    input  logic [9:0]         posy,
    input  logic               blank_n,
    vga_fb_arbiter_if.slave    wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] pix_color
);
    localparam logic [9:0]        H_LAST_FETCH = 10'(H_VIS - (1 << SCALE_LOG2));
    localparam logic [9:0]        H_EOL        = 10'(H_TOTAL - (1 << SCALE_LOG2));
    localparam logic [9:0]        V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]        V_VIS_L      = 10'(V_VIS);
    localparam logic [ADDR_W-1:0] FB_W_A       = ADDR_W'(FB_W);
    localparam logic [ADDR_W:0]   FB_SIZE      = (ADDR_W+1)'(FB_W * FB_H);

    typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

    state_t             state, state_d;
    logic               rd_pending;
    logic [ADDR_W-1:0]  rd_target;
    logic [COLOR_W-1:0] prefetch, disp;

    logic               grp_first, grp_last, fetch_go;
    logic [9:0]         y_next;
    logic [ADDR_W-1:0]  target_c;

    logic [ADDR_W-1:0]  mem_addr_d;
    logic [COLOR_W-1:0] mem_wdata_d;
    logic               mem_we_d, wr_ack_d, wr_ok;

    // Fetch scheduling: next group on this line, or group 0 of the next visible line at end of line.
    always_comb begin
        grp_first = (posx[SCALE_LOG2-1:0] == '0);
        grp_last  = &posx[SCALE_LOG2-1:0];
        y_next    = (posy == V_LAST) ? 10'd0 : posy + 10'd1;
        fetch_go  = 1'b0;
        target_c  = '0;
        if (pix_en && grp_first) begin
            if (posx < H_LAST_FETCH && posy < V_VIS_L) begin
                fetch_go = 1'b1;
                target_c = ADDR_W'(posy >> SCALE_LOG2) * FB_W_A
                         + ADDR_W'(posx >> SCALE_LOG2) + ADDR_W'(1);
            end else if (posx == H_EOL && y_next < V_VIS_L) begin
                fetch_go = 1'b1;
                target_c = ADDR_W'(y_next >> SCALE_LOG2) * FB_W_A;
            end
        end
    end

    always_comb begin
        state_d     = state;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        // The cycle carrying an ack must not re-issue the request it just consumed.
        wr_ok       = wr.wr_req && !wr.wr_ack;
        case (state)
            IDLE: begin
                if (rd_pending) begin
                    state_d    = RD;
                    mem_addr_d = rd_target;
                end else if (wr_ok) begin
                    mem_addr_d  = wr.wr_addr;
                    mem_wdata_d = wr.wr_data;
                    mem_we_d    = ({1'b0, wr.wr_addr} < FB_SIZE);
                    wr_ack_d    = 1'b1;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                state_d = IDLE;
                if (wr_ok) begin
                    mem_addr_d  = wr.wr_addr;
                    mem_wdata_d = wr.wr_data;
                    mem_we_d    = ({1'b0, wr.wr_addr} < FB_SIZE);
                    wr_ack_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr.wr_ack <= 1'b0;
        end else begin
            state     <= state_d;
            mem_addr  <= mem_addr_d;
            mem_we    <= mem_we_d;
            mem_wdata <= mem_wdata_d;
            wr.wr_ack <= wr_ack_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            rd_target  <= '0;
            prefetch   <= '0;
            disp       <= '0;
        end else begin
            if (fetch_go) begin
                rd_pending <= 1'b1;
                rd_target  <= target_c;
            end else if (state == RD) begin
                rd_pending <= 1'b0;
            end
            // RAM data for the address presented during RD is on mem_rdata during CAP.
            if (state == CAP)
                prefetch <= mem_rdata;
            if (pix_en && grp_last)
                disp <= prefetch;
        end
    end

    assign pix_color = blank_n ? disp : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [9:0] posx, posy;
    logic       blank_n;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata, pix_color;

    logic [7:0] ram    [0:32767];
    logic [7:0] exp_fb [0:19199];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  video_on = 1'b0;
    bit  chk_on   = 1'b0;

    vga_fb_arbiter_if #(.ADDR_W(15), .COLOR_W(8)) wr_if ();

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .posx      (posx),
        .posy      (posy),
        .blank_n   (blank_n),
        .wr        (wr_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_color (pix_color)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel timing: two clks per pixel, pix_en in the second, position advances after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!video_on) begin
                pix_en = 1'b0;
            end else if (!pix_en) begin
                pix_en = 1'b1;
            end else begin
                pix_en = 1'b0;
                if (posx == 10'd799) begin
                    posx = 10'd0;
                    posy = (posy == 10'd524) ? 10'd0 : posy + 10'd1;
                end else begin
                    posx = posx + 10'd1;
                end
                blank_n = (posx < 10'd640) && (posy < 10'd480);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && !pix_en) begin
                if (posx < 10'd640 && posy < 10'd480)
                    check_eq($sformatf("pix x%0d y%0d", posx, posy), 32'(pix_color),
                             32'(exp_fb[int'(posy >> 2) * 160 + int'(posx >> 2)]));
                else
                    check_eq($sformatf("blank x%0d y%0d", posx, posy), 32'(pix_color), 32'h0);
            end
        end
    end

    task automatic wait_at(input int x, input int y, input logic en);
        int n;
        for (n = 0; n < 40000; n++) begin
            @(negedge clk);
            if (posx == x && posy == y && pix_en == en) break;
        end
        if (n == 40000) check_eq($sformatf("wait_timeout x%0d y%0d", x, y), 0, 1);
    endtask

    task automatic do_write(input logic [14:0] a, input logic [7:0] d, output int waited);
        wr_if.wr_req  = 1'b1;
        wr_if.wr_addr = a;
        wr_if.wr_data = d;
        for (waited = 1; waited <= 40; waited++) begin
            @(negedge clk);
            if (wr_if.wr_ack) break;
        end
        if (waited > 40) check_eq("wr_ack_timeout", 0, 1);
        wr_if.wr_req = 1'b0;
    endtask

    task automatic start_frame();
        posx     = 10'd796;
        posy     = 10'd524;
        blank_n  = 1'b0;
        video_on = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;
    endtask

    initial begin
        int w, k, max_wait, bad, we_cnt;
        for (int i = 0; i < 32768; i++) ram[i] = init_val(i);
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        for (int i = 0; i < 19200; i++) exp_fb[i] = ram[i];

        rst_n = 1'b0; pix_en = 1'b0; posx = '0; posy = '0; blank_n = 1'b1;
        wr_if.wr_req = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_addr",  32'(mem_addr),  0);
        check_eq("rst_mem_we",    32'(mem_we),    0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
        check_eq("rst_wr_ack",    32'(wr_if.wr_ack), 0);
        check_eq("rst_pix",       32'(pix_color), 0);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();

        // Continuous writer over line 0, targeting undisplayed row 60.
        wait_at(0, 0, 0);
        k = 0; max_wait = 0;
        while (posy == 10'd0 && k < 2000) begin
            do_write(15'(9600 + k), 8'(k * 3 + 1), w);
            exp_fb[9600 + k] = 8'(k * 3 + 1);
            if (w > max_wait) max_wait = w;
            k++;
        end
        check_eq("wr_max_wait_le4", 32'(max_wait <= 4), 1);
        check_eq("cont_ack_count_ge300", 32'(k >= 300), 1);

        // Row 1 write ahead of line 4.
        do_write(15'd160, 8'h7E, w);
        exp_fb[160] = 8'h7E;
        bad = 0;
        for (int i = 0; i < k; i++) if (ram[9600 + i] !== 8'(i * 3 + 1)) bad++;
        check_eq("cont_data_bad", 32'(bad), 0);
        wait_at(1, 3, 0);
        check_eq("line3_unaffected", 32'(pix_color), 32'h11);
        wait_at(1, 4, 0);
        check_eq("line4_row1", 32'(pix_color), 32'h7E);

        // Request raised the clk after a fetch trigger at posx 40 of line 8.
        wait_at(40, 8, 1);
        @(negedge clk);
        wr_if.wr_req = 1'b1; wr_if.wr_addr = 15'd5; wr_if.wr_data = 8'hA5;
        we_cnt = 0;
        @(negedge clk);
        we_cnt += int'(mem_we);
        check_eq("rd_addr",   32'(mem_addr), 331);
        check_eq("rd_we",     32'(mem_we), 0);
        check_eq("rd_no_ack", 32'(wr_if.wr_ack), 0);
        @(negedge clk);
        we_cnt += int'(mem_we);
        check_eq("cap_no_ack", 32'(wr_if.wr_ack), 0);
        @(negedge clk);
        we_cnt += int'(mem_we);
        check_eq("wr_ack",   32'(wr_if.wr_ack), 1);
        check_eq("wr_we",    32'(mem_we), 1);
        check_eq("wr_addr",  32'(mem_addr), 5);
        check_eq("wr_wdata", 32'(mem_wdata), 32'hA5);
        wr_if.wr_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            we_cnt += int'(mem_we);
        end
        check_eq("we_pulses", 32'(we_cnt), 1);
        check_eq("ram5", 32'(ram[5]), 32'hA5);
        exp_fb[5] = 8'hA5;

        // Out-of-range write: acked, never reaches the RAM.
        wait_at(0, 9, 0);
        do_write(15'd19200, 8'h5A, w);
        check_eq("oor_ack", 32'(wr_if.wr_ack), 1);
        check_eq("oor_we",  32'(mem_we), 0);
        repeat (3) @(negedge clk);
        check_eq("oor_ram", 32'(ram[19200]), 32'(init_val(19200)));

        // Reset in the middle of a write.
        wait_at(0, 10, 0);
        chk_on = 1'b0;
        video_on = 1'b0;
        wr_if.wr_req = 1'b1; wr_if.wr_addr = 15'd16000; wr_if.wr_data = 8'h33;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_we) break;
        end
        check_eq("pre_rst_we", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_we",   32'(mem_we), 0);
        check_eq("async_rst_ack",  32'(wr_if.wr_ack), 0);
        check_eq("async_rst_pix",  32'(pix_color), 0);
        check_eq("async_rst_addr", 32'(mem_addr), 0);
        wr_if.wr_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();
        wait_at(2, 0, 0);
        check_eq("f2_px2",  32'(pix_color), 32'h11);
        wait_at(5, 0, 0);
        check_eq("f2_px5",  32'(pix_color), 32'h22);
        wait_at(21, 0, 0);
        check_eq("f2_px21", 32'(pix_color), 32'hA5);
        wait_at(1, 4, 0);
        check_eq("f2_line4", 32'(pix_color), 32'h7E);
        wait_at(0, 5, 0);
        chk_on = 1'b0;
        video_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
